// File: rtl/serial_add_pkg.sv
// serial_add_pkg: FSM state type and default operand width shared by the serial adder.
package serial_add_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: single-bit full adder used as the serial adder's datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder with valid/ready handshakes, one bit per clock, LSB first.
// Optional signed-overflow flag port ovf is built only when OVF_FLAG_EN is defined.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic [CW-1:0]    cnt_q;
    logic             c_q, in_ready_q, out_valid_q, fa_s, fa_co;
`ifdef OVF_FLAG_EN
    logic             ovf_q;
    assign ovf = ovf_q;
`endif

    fa_cell u_fa (.a(a_q[0]), .b(b_q[0]), .cin(c_q), .sum(fa_s), .cout(fa_co));

    // new bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB
    assign sum_d     = {fa_s, sum_q[WIDTH-1:1]};
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = c_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
`ifdef OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q        <= a;
                    b_q        <= b;
                    c_q        <= cin;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= SHIFT;
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    sum_q <= sum_d;
                    c_q   <= fa_co;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
`ifdef OVF_FLAG_EN
                        ovf_q       <= c_q ^ fa_co;
`endif
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and sampled-sweep checks of serial_add_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, cin, in_ready, out_valid, cout;
    logic [W-1:0] a, b, sum;
    logic         iv4, or4, c4, ir4, ov4, co4;
    logic [3:0]   a4, b4, s4;
`ifdef OVF_FLAG_EN
    logic         ovf, ovf4;
`endif
    int           total = 0, fails = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef OVF_FLAG_EN
        , .ovf(ovf)
`endif
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(c4), .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4)
`ifdef OVF_FLAG_EN
        , .ovf(ovf4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // offer one operand set, then wait for the result and check latency and value
    task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        chk("in_ready_idle", in_ready, 1);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~va; b = ~vb;
    endtask

    task automatic wait_result(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        logic [W:0] m;
        int lat;
        lat = 0;
        m = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, W);
        chk("sum", sum, m[W-1:0]);
        chk("cout", cout, m[W]);
    endtask

    task automatic drain;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        start_op(va, vb, vc);
        wait_result(va, vb, vc);
        drain();
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
        iv4 = 0; or4 = 0; a4 = 0; b4 = 0; c4 = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0;
        @(negedge clk);

        op(8'h0F, 8'h01, 1'b0);
        op(8'hFF, 8'h01, 1'b0);
`ifdef OVF_FLAG_EN
        chk("ovf_ff01", ovf, 0);
        start_op(8'h7F, 8'h01, 1'b0);
        wait_result(8'h7F, 8'h01, 1'b0);
        chk("ovf_7f01", ovf, 1);
        drain();
        start_op(8'h80, 8'h80, 1'b0);
        wait_result(8'h80, 8'h80, 1'b0);
        chk("ovf_8080", ovf, 1);
        drain();
`endif
        op(8'hFF, 8'hFF, 1'b1);
        op(8'h00, 8'h00, 1'b0);
        op(8'hA5, 8'h5A, 1'b1);

        start_op(8'h3C, 8'h4D, 1'b1);
        wait_result(8'h3C, 8'h4D, 1'b1);
        for (int i = 0; i < 5; i++) begin
            a = 8'(i * 37); b = 8'h11; in_valid = i[0];
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, 8'h8A);
            chk("hold_cout", cout, 0);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        drain();
        op(8'h12, 8'h34, 1'b0);

        start_op(8'h55, 8'hAA, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        repeat (W + 2) @(negedge clk);
        chk("midrst_no_result", out_valid, 0);
        op(8'h03, 8'h04, 1'b1);
        chk("op_030401_sum", sum, 8'h08);

        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            op(ra, rb, rc);
        end

        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w4_latency", lat, 4);
        chk("w4_sum", s4, 4'hF);
        chk("w4_cout", co4, 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
